// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard controller.
// Forward-select codes, the shadow-stage record and its bubble value.
package fwd_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // A stage supplies a value for rs only if it really writes a non-x0 register equal to rs.
  function automatic logic writes_reg(input logic wr, input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and hazard/forwarding response bundle between the pipeline and the controller.
// The pipeline side is the master; the controller is the slave.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_regwrite_i;
  logic                  id_memread_i;
  logic                  flush_i;
  logic [1:0]            forward_a_o;
  logic [1:0]            forward_b_o;
  logic                  stall_o;
  logic                  pc_write_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
    input  forward_a_o, forward_b_o, stall_o, pc_write_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
    output forward_a_o, forward_b_o, stall_o, pc_write_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Per-operand forward select: compares one EX source against the EX/MEM and MEM/WB writers.
// EX/MEM is checked last so the youngest producer overrides an older one.
module fwd_hazard_ctrl_fwd_sel
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_exmem_wr,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_memwb_wr,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  output logic [1:0]            o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (writes_reg(i_memwb_wr, i_memwb_rd, i_rs)) o_sel = FWD_WB;
    if (writes_reg(i_exmem_wr, i_exmem_rd, i_rs)) o_sel = FWD_MEM;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and load-use hazard controller for a 5-stage pipeline.
// Shadows rs/rd/regwrite/memread through ID/EX, EX/MEM and MEM/WB and counts stall cycles.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W,  // must match REG_W, the width of the stage record
  parameter int CNT_W      = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fwd_hazard_ctrl_if.slave   ctrl
);

  stage_t           r_idex;
  stage_t           r_exmem;
  stage_t           r_memwb;
  logic [CNT_W-1:0] r_stall_cnt;

  stage_t           w_idex_nxt;
  logic             w_stall;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_unused_memwb;

  // Flush overrides the hazard: a squashed instruction cannot stall.
  assign w_stall = ctrl.id_valid_i && !ctrl.flush_i && r_idex.memread &&
                   (r_idex.rd != '0) &&
                   ((r_idex.rd == ctrl.id_rs1_i) || (r_idex.rd == ctrl.id_rs2_i));

  always_comb begin
    w_idex_nxt = BUBBLE;
    if (ctrl.id_valid_i && !w_stall && !ctrl.flush_i) begin
      w_idex_nxt.rs1      = ctrl.id_rs1_i;
      w_idex_nxt.rs2      = ctrl.id_rs2_i;
      w_idex_nxt.rd       = ctrl.id_rd_i;
      w_idex_nxt.regwrite = ctrl.id_regwrite_i;
      w_idex_nxt.memread  = ctrl.id_memread_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idex      <= BUBBLE;
      r_exmem     <= BUBBLE;
      r_memwb     <= BUBBLE;
      r_stall_cnt <= '0;
    end else begin
      r_idex  <= w_idex_nxt;
      r_exmem <= r_idex;
      r_memwb <= r_exmem;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  fwd_hazard_ctrl_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs       (r_idex.rs1),
    .i_exmem_wr (r_exmem.regwrite),
    .i_exmem_rd (r_exmem.rd),
    .i_memwb_wr (r_memwb.regwrite),
    .i_memwb_rd (r_memwb.rd),
    .o_sel      (w_fwd_a)
  );

  fwd_hazard_ctrl_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs       (r_idex.rs2),
    .i_exmem_wr (r_exmem.regwrite),
    .i_exmem_rd (r_exmem.rd),
    .i_memwb_wr (r_memwb.regwrite),
    .i_memwb_rd (r_memwb.rd),
    .o_sel      (w_fwd_b)
  );

  // MEM/WB only ever supplies rd/regwrite; its source fields are carried for debug visibility.
  assign w_unused_memwb = ^{r_memwb.rs1, r_memwb.rs2, r_memwb.memread};

  assign ctrl.forward_a_o = w_fwd_a;
  assign ctrl.forward_b_o = w_fwd_b;
  assign ctrl.stall_o     = w_stall;
  assign ctrl.pc_write_o  = !w_stall;
  assign ctrl.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, mid-run reset,
// randomized traffic against an instruction-level pipeline model, and counter saturation.
module tb_fwd_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       id_valid, id_regwrite, id_memread, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_sat ();

  assign bus.id_valid_i        = id_valid;
  assign bus.id_rs1_i          = id_rs1;
  assign bus.id_rs2_i          = id_rs2;
  assign bus.id_rd_i           = id_rd;
  assign bus.id_regwrite_i     = id_regwrite;
  assign bus.id_memread_i      = id_memread;
  assign bus.flush_i           = flush;
  assign bus_sat.id_valid_i    = id_valid;
  assign bus_sat.id_rs1_i      = id_rs1;
  assign bus_sat.id_rs2_i      = id_rs2;
  assign bus_sat.id_rd_i       = id_rd;
  assign bus_sat.id_regwrite_i = id_regwrite;
  assign bus_sat.id_memread_i  = id_memread;
  assign bus_sat.flush_i       = flush;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .clk_i (clk_i), .rst_i (rst_i), .ctrl (bus)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_dut_sat (
    .clk_i (clk_i), .rst_i (rst_i), .ctrl (bus_sat)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
  } vec_t;

  // One instruction as it travels past ID; live = 0 marks a bubble.
  typedef struct {
    bit         live;
    bit         wr;
    bit         ld;
    logic [4:0] rd, rs1, rs2;
  } instr_t;

  vec_t   tbl[$];
  instr_t pipe[$];   // pipe[0] in EX, pipe[1] in MEM, pipe[2] in WB
  int     m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t row(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic rw, input logic mr,
                               input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                               input logic es);
    vec_t r;
    r.v = v; r.rs1 = s1; r.rs2 = s2; r.rd = d; r.rw = rw; r.mr = mr; r.fl = fl;
    r.ea = ea; r.eb = eb; r.es = es;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  function automatic void model_reset();
    instr_t b;
    b = '{live: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
    pipe.delete();
    repeat (3) pipe.push_back(b);
    m_cnt = 0;
  endfunction

  // Youngest older instruction that writes the EX source supplies it.
  function automatic logic [1:0] m_fwd(input bit op_b);
    logic [4:0] rs;
    if (!pipe[0].live) return 2'b00;
    rs = op_b ? pipe[0].rs2 : pipe[0].rs1;
    for (int age = 1; age <= 2; age++) begin
      if (pipe[age].live && pipe[age].wr && pipe[age].rd != 5'd0 && pipe[age].rd == rs)
        return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  // Drive one ID-stage cycle, compare against the model, then advance the model past the edge.
  task automatic mstep(input string tag, input logic v, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d, input logic rw,
                       input logic mr, input logic fl);
    logic   es;
    int     sat;
    instr_t n;
    @(negedge clk_i);
    drive(v, s1, s2, d, rw, mr, fl);
    #1;
    es  = v && !fl && pipe[0].live && pipe[0].ld && pipe[0].rd != 5'd0 &&
          (pipe[0].rd == s1 || pipe[0].rd == s2);
    sat = (m_cnt > 15) ? 15 : m_cnt;
    chk({tag, " fwd_a"}, 32'(bus.forward_a_o), 32'(m_fwd(1'b0)));
    chk({tag, " fwd_b"}, 32'(bus.forward_b_o), 32'(m_fwd(1'b1)));
    chk({tag, " stall"}, 32'(bus.stall_o), 32'(es));
    chk({tag, " pc_write"}, 32'(bus.pc_write_o), 32'(!es));
    chk({tag, " cnt"}, bus.stall_cnt_o, 32'(m_cnt));
    chk({tag, " cnt_sat"}, 32'(bus_sat.stall_cnt_o), 32'(sat));
    n = '{live: 1'b0, wr: 1'b0, ld: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0};
    if (v && !es && !fl) n = '{live: 1'b1, wr: rw, ld: mr, rd: d, rs1: s1, rs2: s2};
    pipe.push_front(n);
    void'(pipe.pop_back());
    if (es) m_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t nv;
    int   stalls;
    logic [4:0] r1, r2, rd;
    nv = row(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // add x5; sub x9 = x5 - x3 -> EX/MEM forward on A
    tbl.push_back(row(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 5, 3, 9, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    tbl.push_back(nv); tbl.push_back(nv);
    // add x6; nop; and rs2 = x6 -> MEM/WB forward on B
    tbl.push_back(row(1, 1, 2, 6, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(nv);
    tbl.push_back(row(1, 3, 6, 10, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
    tbl.push_back(nv); tbl.push_back(nv);
    // add x6; add x6; or rs1 = x6 -> EX/MEM wins
    tbl.push_back(row(1, 1, 2, 6, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 3, 4, 6, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 6, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    tbl.push_back(nv); tbl.push_back(nv);
    // lw x7; add x7, x7 (held one cycle by the stall) -> both operands from MEM/WB
    tbl.push_back(row(1, 1, 0, 7, 1, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 7, 7, 12, 1, 0, 0, 2'b00, 2'b00, 1));
    tbl.push_back(row(1, 7, 7, 12, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0));
    tbl.push_back(nv); tbl.push_back(nv);
    // lw x0; use x0 -> never stalls, never forwards
    tbl.push_back(row(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 0, 0, 13, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(nv); tbl.push_back(nv);
    // lw x8; dependent squashed by flush -> no stall, bubble in EX
    tbl.push_back(row(1, 1, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 8, 1, 14, 1, 0, 1, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(nv); tbl.push_back(nv);
    // lw x8; dependent through rs2
    tbl.push_back(row(1, 2, 3, 8, 1, 1, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(1, 4, 8, 15, 1, 0, 0, 2'b00, 2'b00, 1));
    tbl.push_back(row(1, 4, 8, 15, 1, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
    tbl.push_back(nv); tbl.push_back(nv);

    do_reset();
    stalls = 0;
    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d fwd_a", i), 32'(bus.forward_a_o), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d fwd_b", i), 32'(bus.forward_b_o), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d stall", i), 32'(bus.stall_o), 32'(tbl[i].es));
      chk($sformatf("tbl%0d pc_write", i), 32'(bus.pc_write_o), 32'(!tbl[i].es));
      chk($sformatf("tbl%0d cnt", i), bus.stall_cnt_o, 32'(stalls));
      if (tbl[i].es) stalls++;
    end

    // Mid-operation reset: live forward and stall must vanish before the next edge.
    @(negedge clk_i); drive(1, 3, 3, 1, 1, 0, 0);
    @(negedge clk_i); drive(1, 1, 2, 9, 1, 1, 0);
    @(negedge clk_i); drive(1, 9, 3, 16, 1, 0, 0);
    #1;
    chk("pre_rst fwd_a", 32'(bus.forward_a_o), 32'(2'b10));
    chk("pre_rst stall", 32'(bus.stall_o), 32'd1);
    chk("pre_rst cnt", bus.stall_cnt_o, 32'(stalls));
    #1;
    rst_i = 1'b1;
    drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    #1;
    chk("rst fwd_a", 32'(bus.forward_a_o), 32'd0);
    chk("rst fwd_b", 32'(bus.forward_b_o), 32'd0);
    chk("rst stall", 32'(bus.stall_o), 32'd0);
    chk("rst pc_write", 32'(bus.pc_write_o), 32'd1);
    chk("rst cnt", bus.stall_cnt_o, 32'd0);
    chk("rst cnt_sat", 32'(bus_sat.stall_cnt_o), 32'd0);
    do_reset();

    // Random traffic over a small register set so hazards are frequent.
    for (int k = 0; k < 600; k++) begin
      r1 = 5'($urandom_range(3, 0));
      r2 = 5'($urandom_range(3, 0));
      rd = 5'($urandom_range(3, 0));
      mstep($sformatf("rnd%0d", k), 1'($urandom_range(3, 0) != 0), r1, r2, rd,
            1'($urandom), 1'($urandom), 1'($urandom_range(7, 0) == 0));
    end

    // Self-dependent load held in ID: a stall every other cycle, 20 in 40 cycles.
    do_reset();
    for (int k = 0; k < 40; k++) mstep($sformatf("sat%0d", k), 1, 7, 0, 7, 1, 1, 0);
    @(negedge clk_i);
    #1;
    chk("sat cnt32", bus.stall_cnt_o, 32'd20);
    chk("sat cnt4", 32'(bus_sat.stall_cnt_o), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the EX-stage operand forwarding multiplexers in the 5-stage RISC-V pipeline.
- Tracks destination-register state through ID/EX, EX/MEM and MEM/WB in its own shadow pipeline.
- Produces the 2-bit forward-select codes for both EX operands, detects load-use hazards and issues stall/bubble control.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, stall-counter width.

Ports:
- clk_i  in  1  pipeline clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs1_i  in  REG_ADDR_W  ID-stage source register 1.
- id_rs2_i  in  REG_ADDR_W  ID-stage source register 2.
- id_rd_i  in  REG_ADDR_W  ID-stage destination register.
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the ID-stage instruction (taken branch).
- forward_a_o  out  2  EX operand-1 select: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB write data.
- forward_b_o  out  2  EX operand-2 select, same encoding.
- stall_o  out  1  load-use stall: hold PC and IF/ID.
- pc_write_o  out  1  equals ~stall_o.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: one clock domain clk_i; rst_i asynchronous, active-high. All shadow stages cleared (valid, regwrite, memread = 0; register fields = 0); stall_cnt = 0. Outputs during reset: forward_a_o/forward_b_o = 00, stall_o = 0, pc_write_o = 1, stall_cnt_o = 0. Mid-operation reset drops all tracked writers immediately.
- Shadow pipeline, every rising edge: EXMEM <= IDEX; MEMWB <= EXMEM.
  - IDEX <= {rs1, rs2, rd, regwrite, memread} from ID when id_valid_i & ~stall_o & ~flush_i.
  - Otherwise IDEX <= bubble (regwrite = 0, memread = 0, fields = 0).
- Forwarding (combinational from the registered IDEX/EXMEM/MEMWB; no added latency). For operand A, using IDEX.rs1:
  - 10 if EXMEM.regwrite & EXMEM.rd != 0 & EXMEM.rd == IDEX.rs1;
  - else 01 if MEMWB.regwrite & MEMWB.rd != 0 & MEMWB.rd == IDEX.rs1;
  - else 00.
  - EX/MEM has priority when both stages match (youngest value wins).
  - Operand B is identical, using IDEX.rs2.
  - Code 11 is never produced.
- Load-use stall (combinational): stall_o = id_valid_i & ~flush_i & IDEX.memread & IDEX.rd != 0 & (IDEX.rd == id_rs1_i | IDEX.rd == id_rs2_i).
  - Exactly one stall cycle per load-use pair: the next edge inserts a bubble, after which the load sits in EX/MEM and is not itself forwardable from the ALU result path; it reaches MEM/WB one cycle later.
  - Rule: after the bubble, a dependent in EX sees the load in MEM/WB and gets select 01.
- x0 rule: a destination of 0 never forwards and never stalls.
- Simultaneous flush_i and hazard: flush wins; stall_o = 0; a bubble enters IDEX.
- Counter: stall_cnt increments by 1 on each edge with stall_o = 1. It saturates at all-ones with no wrap.

Decomposition:
- Shared package: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10; a stage-record typedef {rs1, rs2, rd, regwrite, memread}; BUBBLE constant.
- One natural sub-module: fwd_sel, the combinational per-operand compare/priority. Instantiate it twice (A, B).

Test Plan:
- Reset: assert rst_i with id inputs randomized -> forward_a_o = forward_b_o = 00, stall_o = 0, pc_write_o = 1, stall_cnt_o = 0, asynchronously before the next edge.
- EX/MEM forward: issue "add x5" then "sub rs1 = x5" on the next cycle -> in the sub's EX cycle forward_a_o = 10, forward_b_o = 00.
- MEM/WB and priority:
  - add x6, nop, then "and rs2 = x6" -> forward_b_o = 01.
  - add x6; add x6; "or rs1 = x6" -> forward_a_o = 10 (EX/MEM priority).
- Load-use: "lw x7" followed by "add rs1 = x7, rs2 = x7" -> stall_o = 1 and pc_write_o = 0 for exactly one cycle; stall_cnt_o goes 0 -> 1; in the add's EX cycle forward_a_o = forward_b_o = 01.
- x0 and flush:
  - "lw x0" followed by "rs1 = x0" -> no stall and forward 00.
  - "lw x8" followed by "rs1 = x8" with flush_i = 1 in the same cycle -> stall_o = 0, and the following cycle shows no forwarding.
- Saturation: with CNT_W = 4, hold a load-use pattern for 20 stall cycles -> stall_cnt_o reaches 15 and stays at 15.
